// File: rtl/dma_bus_master_pkg.sv
// Shared types and constants for the DMA bus master.
// State encoding, address step and idle strobe level used by the FSM and address counters.
package dma_bus_master_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    NEXT = 3'd4,
    FIN  = 3'd5
  } dma_state_e;

  localparam int   ADDR_STEP   = 2;
  localparam logic STROBE_IDLE = 1'b1;

endpackage

// File: rtl/dma_bus_master_addr_counter.sv
// Word-aligned bus address register: loads a start address with bit 0 cleared,
// then steps by one 16-bit word per increment, wrapping modulo 2^ADDR_W.
module dma_addr_counter
  import dma_bus_master_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = {load_addr[ADDR_W-1:1], 1'b0};
    end else if (inc) begin
      addr_d = addr_q + ADDR_W'(ADDR_STEP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/dma_bus_master.sv
// DMA bus master: copies COUNT words from SRC to DST over the shared CPU bus,
// arbitrating through BUSREQ/BUSGNT. Define DMA_FILL_EN to add the constant-fill mode.
module dma_bus_master
  import dma_bus_master_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 12,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] SRC,
  input  logic [ADDR_W-1:0] DST,
  input  logic [LEN_W-1:0]  COUNT,
  input  logic              START,
`ifdef DMA_FILL_EN
  input  logic              FILL,
  input  logic [DATA_W-1:0] FILL_DATA,
`endif
  output logic              BUSY,
  output logic              DONE,
  output logic              IRQ,
  input  logic              IRQ_ACK,
  output logic              BUSREQ,
  input  logic              BUSGNT,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] DOUT,
  input  logic [DATA_W-1:0] DIN,
  output logic              RDN,
  output logic              WR0N,
  output logic              WR1N
);

  localparam int LAT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  dma_state_e        state_q, state_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              irq_q, irq_d;
  logic              addr_load, addr_inc, skip_rd;
  logic [ADDR_W-1:0] src_addr, dst_addr;

`ifdef DMA_FILL_EN
  logic fill_q, fill_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fill_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign skip_rd = fill_q;
`else
  assign skip_rd = 1'b0;
`endif

  dma_addr_counter #(.ADDR_W(ADDR_W)) u_src_cnt (
    .clk       (CLK),
    .rst       (RESET),
    .load      (addr_load),
    .inc       (addr_inc),
    .load_addr (SRC),
    .addr      (src_addr)
  );

  dma_addr_counter #(.ADDR_W(ADDR_W)) u_dst_cnt (
    .clk       (CLK),
    .rst       (RESET),
    .load      (addr_load),
    .inc       (addr_inc),
    .load_addr (DST),
    .addr      (dst_addr)
  );

  // Next-state logic; a word that has entered RD or WR finishes regardless of BUSGNT.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    data_d    = data_q;
    lat_d     = lat_q;
    irq_d     = irq_q & ~IRQ_ACK;
    addr_load = 1'b0;
    addr_inc  = 1'b0;
`ifdef DMA_FILL_EN
    fill_d    = fill_q;
`endif
    case (state_q)
      IDLE: begin
        if (START) begin
          if (COUNT != '0) begin
            addr_load = 1'b1;
            count_d   = COUNT;
            state_d   = REQ;
`ifdef DMA_FILL_EN
            fill_d    = FILL;
            if (FILL) begin
              data_d = FILL_DATA;
            end
`endif
          end else begin
            state_d = FIN;
          end
        end
      end
      REQ: begin
        if (BUSGNT) begin
          lat_d   = '0;
          state_d = skip_rd ? WR : RD;
        end
      end
      RD: begin
        if (lat_q == LAT_W'(RD_LAT)) begin
          data_d  = DIN;
          state_d = WR;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      WR: state_d = NEXT;
      NEXT: begin
        addr_inc = 1'b1;
        count_d  = count_q - LEN_W'(1);
        lat_d    = '0;
        if (count_q == LEN_W'(1)) begin
          state_d = FIN;
        end else if (BUSGNT) begin
          state_d = skip_rd ? WR : RD;
        end else begin
          state_d = REQ;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Setting the interrupt takes priority over a coincident acknowledge.
    if (state_d == FIN) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      count_q <= '0;
      data_q  <= '0;
      lat_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      lat_q   <= lat_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    BUSREQ = 1'b0;
    ADDR   = '0;
    DOUT   = '0;
    RDN    = STROBE_IDLE;
    WR0N   = STROBE_IDLE;
    WR1N   = STROBE_IDLE;
    case (state_q)
      REQ, NEXT: BUSREQ = 1'b1;
      RD: begin
        BUSREQ = 1'b1;
        ADDR   = src_addr;
        RDN    = ~STROBE_IDLE;
      end
      WR: begin
        BUSREQ = 1'b1;
        ADDR   = dst_addr;
        DOUT   = data_q;
        WR0N   = ~STROBE_IDLE;
        WR1N   = ~STROBE_IDLE;
      end
      default: BUSREQ = 1'b0;
    endcase
  end

  assign BUSY = BUSREQ;
  assign DONE = (state_q == FIN);
  assign IRQ  = irq_q;

endmodule
